// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcodes and the trainer instruction layout.
package instr_sequencer_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_HLT = 4'b1111
  } opcode_t;

  // Field layout of one trainer instruction word.
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] dst;
    logic [1:0] src;
  } instr_t;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] raw);
    return (raw >> OPC_LSB) == INSTR_W'(OP_HLT);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store for the sequencer: one write port, one read port with a
// registered read that can be held with rd_en.
module prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; a cleared program is tracked by length only,
  // which keeps this mappable onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Trainer instruction sequencer: loads a program from DIP switches and issues
// it to a CPU core over a valid/ready handshake, free-running or single-step.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        trainer_dip,
  input  logic              load_pulse,
  input  logic              run_pulse,
  input  logic              step_pulse,
  input  logic              clr_pulse,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_full,
  output logic              halted
);

  localparam int LEN_W = ADDR_W + 1;

  seq_state_t         state;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_en;
  logic               wr_en;
  logic               issuing;
  logic [LEN_W-1:0]   pc_inc;

  assign load_full = (prog_len == LEN_W'(DEPTH));
  assign issuing   = (state == S_RUN) || (state == S_STEP);
  assign pc_inc    = {1'b0, pc} + LEN_W'(1);
  assign wr_en     = ((state == S_IDLE) || (state == S_HALT)) && load_pulse &&
                     !clr_pulse && !rst && !load_full;

  // The RAM always holds the word the FSM will need at the next update:
  // mem[pc] before the first presentation, mem[pc+1] while one is presented.
  always_comb begin
    rd_en   = 1'b1;
    rd_addr = pc;
    if (issuing) begin
      if (!instr_valid)     rd_addr = pc + ADDR_W'(1);
      else if (instr_ready) rd_addr = pc + ADDR_W'(2);
      else                  rd_en   = 1'b0;
    end else if (state == S_HALT) begin
      rd_addr = '0;
    end
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH (INSTR_W)
  ) u_prog_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(prog_len[ADDR_W-1:0]),
    .wr_data(trainer_dip),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      prog_len    <= '0;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (clr_pulse) begin
      state       <= S_IDLE;
      pc          <= '0;
      prog_len    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_pulse) begin
            if (!load_full) prog_len <= prog_len + LEN_W'(1);
          end else if (run_pulse || step_pulse) begin
            if ({1'b0, pc} < prog_len) begin
              state <= run_pulse ? S_RUN : S_STEP;
            end else begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end

        S_RUN, S_STEP: begin
          if (!instr_valid) begin
            // First presentation after entry; a HLT word is never shown.
            if (is_hlt(rd_data)) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              instr       <= rd_data;
              instr_valid <= 1'b1;
            end
          end else if (instr_ready) begin
            pc <= pc_inc[ADDR_W-1:0];
            if (pc_inc == prog_len || (state == S_RUN && is_hlt(rd_data))) begin
              instr_valid <= 1'b0;
              state       <= S_HALT;
              halted      <= 1'b1;
            end else if (state == S_STEP) begin
              instr_valid <= 1'b0;
              state       <= S_IDLE;
            end else begin
              instr <= rd_data;
            end
          end
        end

        S_HALT: begin
          if (load_pulse) begin
            state  <= S_IDLE;
            halted <= 1'b0;
            if (!load_full) prog_len <= prog_len + LEN_W'(1);
          end else if (run_pulse) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= (prog_len != '0) ? S_RUN : S_IDLE;
          end
        end

        default: begin
          state  <= S_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: an issue-order/program-length model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_instr_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] trainer_dip;
  logic       load_pulse, run_pulse, step_pulse, clr_pulse;
  logic [7:0] instr;
  logic       instr_valid, instr_ready;
  logic [3:0] pc;
  logic [4:0] prog_len;
  logic       load_full, halted;

  int checks = 0;
  int errors = 0;

  // Model: program contents/length and the queue of words still to be issued.
  logic [7:0] mmem [16];
  int         mlen = 0;
  logic [7:0] exp_q [$];
  int         hs_count = 0;
  bit         mbusy = 0;
  bit         cmp_en = 0;

  instr_sequencer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .trainer_dip(trainer_dip),
    .load_pulse (load_pulse),
    .run_pulse  (run_pulse),
    .step_pulse (step_pulse),
    .clr_pulse  (clr_pulse),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc),
    .prog_len   (prog_len),
    .load_full  (load_full),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("prog_len", prog_len, mlen);
      check("load_full", load_full, (mlen == 16));
      if (instr_valid) begin
        if (exp_q.size() == 0) check("unexpected_issue", instr_valid, 0);
        else                   check("issue_order", instr, exp_q[0]);
      end
      if (instr_valid && instr_ready && !clr_pulse && !rst && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
      if (rst || clr_pulse) begin
        exp_q.delete();
        mlen = 0;
      end else if (load_pulse && !mbusy && mlen < 16) begin
        mmem[mlen] = trainer_dip;
        mlen++;
      end
    end
  end

  task automatic do_load(input logic [7:0] d);
    trainer_dip = d;
    load_pulse  = 1'b1;
    tick();
    load_pulse  = 1'b0;
  endtask

  task automatic do_clr();
    clr_pulse = 1'b1;
    tick();
    clr_pulse = 1'b0;
    mbusy     = 0;
  endtask

  // Free-running issue from 'start' stops at the program end or at a HLT word.
  task automatic start_run(input int start);
    for (int i = start; i < mlen; i++) begin
      if (mmem[i][7:4] == 4'hF) break;
      exp_q.push_back(mmem[i]);
    end
    mbusy     = 1;
    run_pulse = 1'b1;
    tick();
    run_pulse = 1'b0;
  endtask

  task automatic start_step(input int start);
    if (start < mlen && mmem[start][7:4] != 4'hF) exp_q.push_back(mmem[start]);
    mbusy      = 1;
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check("halt_reached", halted, 1);
    mbusy = 0;
  endtask

  initial begin
    int hs0;
    rst = 1'b1;
    trainer_dip = 8'h00;
    load_pulse = 0; run_pulse = 0; step_pulse = 0; clr_pulse = 0;
    instr_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_instr", instr, 8'h00);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_halted", halted, 0);
    check("rst_load_full", load_full, 0);
    cmp_en = 1;

    // Three-word program issued back to back.
    instr_ready = 1'b1;
    do_load(8'h15); do_load(8'h16); do_load(8'h2D);
    check("len3", prog_len, 3);
    start_run(0);
    check("entry_not_valid", instr_valid, 0);
    tick(); check("run_w0", instr, 8'h15); check("run_v0", instr_valid, 1);
    tick(); check("run_w1", instr, 8'h16); check("run_v1", instr_valid, 1);
    tick(); check("run_w2", instr, 8'h2D); check("run_v2", instr_valid, 1);
    tick();
    check("run_done_valid", instr_valid, 0);
    check("run_halted", halted, 1);
    check("run_pc", pc, 3);
    mbusy = 0;

    // Restart from HALT, then a load from HALT appends and resumes at pc.
    start_run(0);
    wait_halt(20);
    check("rerun_pc", pc, 3);
    do_load(8'h24);
    check("halt_load_exit", halted, 0);
    check("halt_load_len", prog_len, 4);
    start_run(3);
    tick(); check("resume_w", instr, 8'h24);
    wait_halt(20);
    check("resume_pc", pc, 4);
    check("run_q_drained", exp_q.size(), 0);

    // Fill all 16 entries, then one ignored load.
    do_clr();
    for (int i = 0; i < 16; i++) do_load(8'h10 + 8'(i));
    do_load(8'hF5);
    check("full_flag", load_full, 1);
    check("full_len", prog_len, 16);
    start_run(0);
    tick(); check("full_mem0", instr, 8'h10);
    wait_halt(40);
    check("full_q_drained", exp_q.size(), 0);

    // Back-pressure: word 0 held stable; pulses during RUN ignored.
    do_clr();
    do_load(8'h21); do_load(8'h22); do_load(8'h23);
    instr_ready = 1'b0;
    start_run(0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr, 8'h21);
      check("stall_valid", instr_valid, 1);
      check("stall_pc", pc, 0);
      if (i == 2) begin
        trainer_dip = 8'h99; load_pulse = 1'b1; step_pulse = 1'b1; run_pulse = 1'b1;
      end
      tick();
      load_pulse = 1'b0; step_pulse = 1'b0; run_pulse = 1'b0;
    end
    instr_ready = 1'b1;
    wait_halt(20);
    check("stall_end_pc", pc, 3);
    check("stall_q_drained", exp_q.size(), 0);

    // Embedded HLT stops issue after the first word.
    do_clr();
    do_load(8'h15); do_load(8'hF0); do_load(8'h16);
    start_run(0);
    wait_halt(20);
    check("hlt_pc", pc, 1);
    check("hlt_valid", instr_valid, 0);
    check("hlt_q_drained", exp_q.size(), 0);

    // Single-step: one handshake per step, IDLE between, HALT at program end.
    do_clr();
    do_load(8'h31); do_load(8'h32);
    hs0 = hs_count;
    start_step(0);
    repeat (3) tick();
    check("step1_hs", hs_count - hs0, 1);
    check("step1_idle", halted, 0);
    check("step1_valid", instr_valid, 0);
    check("step1_pc", pc, 1);
    hs0 = hs_count;
    start_step(1);
    repeat (3) tick();
    check("step2_hs", hs_count - hs0, 1);
    check("step2_halted", halted, 1);
    check("step2_pc", pc, 2);
    hs0 = hs_count;
    start_step(2);
    repeat (3) tick();
    check("step3_hs", hs_count - hs0, 0);
    check("step3_halted", halted, 1);
    mbusy = 0;

    // clr together with run_pulse while a handshake is pending.
    do_clr();
    do_load(8'h41); do_load(8'h42); do_load(8'h43); do_load(8'h44);
    instr_ready = 1'b0;
    start_run(0);
    tick();
    check("clr_pre_valid", instr_valid, 1);
    clr_pulse = 1'b1; run_pulse = 1'b1; instr_ready = 1'b1;
    tick();
    clr_pulse = 1'b0; run_pulse = 1'b0;
    mbusy = 0;
    check("clr_valid", instr_valid, 0);
    check("clr_len", prog_len, 0);
    check("clr_pc", pc, 0);
    check("clr_halted", halted, 0);

    // rst together with run_pulse mid-RUN.
    do_load(8'h51); do_load(8'h52); do_load(8'h53);
    start_run(0);
    tick(); tick();
    check("rst_pre_valid", instr_valid, 1);
    rst = 1'b1; run_pulse = 1'b1;
    tick();
    rst = 1'b0; run_pulse = 1'b0;
    mbusy = 0;
    check("rstrun_valid", instr_valid, 0);
    check("rstrun_len", prog_len, 0);
    check("rstrun_instr", instr, 8'h00);
    check("rstrun_pc", pc, 0);
    check("rstrun_halted", halted, 0);
    tick();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: program memory entries.
REQ-002 Parameter ADDR_W, default 4: pointer width, equal to log2(DEPTH).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 trainer_dip  in  8  instruction to load: opcode[7:4], dst[3:2], src[1:0].
REQ-006 load_pulse  in  1  one-cycle debounced pulse; writes trainer_dip to program memory.
REQ-007 run_pulse  in  1  one-cycle pulse; starts or continues free-running issue.
REQ-008 step_pulse  in  1  one-cycle pulse; issues exactly one instruction.
REQ-009 clr_pulse  in  1  one-cycle pulse; empties the program.
REQ-010 instr  out  8  instruction presented to the CPU core.
REQ-011 instr_valid  out  1  instr is valid.
REQ-012 instr_ready  in  1  CPU core accepts instr this cycle.
REQ-013 pc  out  ADDR_W  index of the next instruction to issue.
REQ-014 prog_len  out  ADDR_W+1  number of loaded instructions, 0..DEPTH.
REQ-015 load_full  out  1  prog_len == DEPTH.
REQ-016 halted  out  1  sequencer is in HALT.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, STEP and HALT.
REQ-018 IDLE: a load_pulse while prog_len < DEPTH SHALL write mem[prog_len] = trainer_dip and increment prog_len; when load_full is set, the load SHALL be ignored.
REQ-019 IDLE: a run_pulse with pc < prog_len SHALL go to RUN; a step_pulse with pc < prog_len SHALL go to STEP; when pc == prog_len, either pulse SHALL go to HALT.
REQ-020 Simultaneous pulses in IDLE SHALL resolve by priority clr > load > run > step; lower-priority pulses SHALL be dropped.
REQ-021 RUN and STEP: instr_valid SHALL rise the cycle after entry, and instr SHALL equal mem[pc].
REQ-022 instr and instr_valid SHALL be registered and held stable until the cycle with instr_valid && instr_ready (the handshake).
REQ-023 On a RUN handshake, pc SHALL increment; if the new pc < prog_len, the next instruction SHALL be valid in the following cycle (throughput 1/cycle); otherwise instr_valid SHALL drop and the state SHALL go to HALT.
REQ-024 On a STEP handshake, pc SHALL increment, instr_valid SHALL drop the next cycle, and the state SHALL return to IDLE (or go to HALT if pc reaches prog_len).
REQ-025 Opcode 4'b1111 (HLT) SHALL NOT be presented; on reaching it, pc SHALL stay on it and the state SHALL go to HALT.
REQ-026 run_pulse, step_pulse and load_pulse SHALL be ignored in RUN and STEP.
REQ-027 HALT: halted = 1; a run_pulse SHALL set pc = 0 and re-enter RUN (or IDLE if prog_len == 0); a load_pulse SHALL go to IDLE and perform the load.
REQ-028 clr_pulse in any state SHALL set prog_len = 0 and pc = 0, deassert instr_valid next cycle, and go to IDLE; memory contents need not be cleared.
REQ-029 A clr_pulse during a pending handshake SHALL win: the instruction is considered not issued.

Reset
REQ-030 rst SHALL set state = IDLE, pc = 0, prog_len = 0, instr = 8'h00, instr_valid = 0, halted = 0, and load_full = 0.
REQ-031 rst SHALL take priority over all pulses and the handshake in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the opcode constants (NOP 0000, ADD 0001, SUB 0010, HLT 1111), and the instruction field positions.
REQ-033 Program memory SHALL be a sub-module prog_ram (DEPTH x 8, one write port, one read port, registered read), instantiated once.

Verification
REQ-034 Load 8'h15, 8'h16, 8'h2D, then run with instr_ready = 1 -> instr = 15, 16, 2D on three consecutive cycles; then halted = 1 and pc = 3.
REQ-035 Load 16 entries, then one more load -> load_full = 1, prog_len = 16, and mem[0] is unchanged.
REQ-036 Load 3 entries, run, hold instr_ready = 0 for 5 cycles -> instr = entry 0 stays stable with instr_valid = 1 and pc = 0.
REQ-037 Load 8'h15, 8'hF0, 8'h16, then run -> only 15 is issued; halted = 1 with pc = 1.
REQ-038 Load 2 entries, step twice -> each step produces exactly one handshake and returns to IDLE; a third step -> HALT.
REQ-039 Apply clr_pulse and rst mid-RUN, each together with run_pulse -> instr_valid = 0 the next cycle, prog_len = 0, and state = IDLE.
